// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter
// Shares one single-port word memory between instruction fetch (IF) and the
// data stage (DM). Data accesses win contention, but a starvation counter
// forces a fetch grant after MAX_STARVE consecutive denied fetch cycles.
// Fetch returns can be squashed by a branch flush, and no fetch is granted
// while the core is halted.
module mips32_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 3
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              halted,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);

  logic [3:0] starve_cnt;
  logic       if_pend;
  logic       dm_pend;
  logic       ifv;
  logic       starved;

  // Grant selection: DM has priority unless fetch has waited its full budget.
  // Grants are held off entirely while reset is asserted.
  always_comb begin
    ifv     = if_req & ~halted;
    starved = (starve_cnt == STARVE_LIM);
    if_gnt  = 1'b0;
    dm_gnt  = 1'b0;
    if (!rst) begin
      if (ifv && (!dm_req || starved)) begin
        if_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end
    end
  end

  // Memory port mux; an idle port drives all-zero address and data.
  always_comb begin
    mem_en    = if_gnt | dm_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_gnt) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  // Starvation counter: counts consecutive cycles a live fetch is denied.
  always_ff @(posedge clk1) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (ifv && !if_gnt) begin
      if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  // Read-return tracking; stores and flushed fetches leave nothing pending.
  always_ff @(posedge clk1) begin
    if (rst) begin
      if_pend <= 1'b0;
      dm_pend <= 1'b0;
    end else begin
      if_pend <= if_gnt & ~if_flush;
      dm_pend <= dm_gnt & ~dm_we;
    end
  end

  // Return strobes; a flush in the return cycle still squashes the fetch.
  always_comb begin
    if_rvalid = if_pend & ~if_flush & ~rst;
    dm_rvalid = dm_pend & ~rst;
    if_rdata  = mem_rdata;
    dm_rdata  = mem_rdata;
  end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb_mips32_mem_arbiter
// Directed checks of the IF/DM memory arbiter against a small synchronous
// memory model. Unwritten words read back as (address + 0xA).
module tb_mips32_mem_arbiter;

  logic        clk1;
  logic        rst;
  logic        halted;
  logic        if_req;
  logic [9:0]  if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [9:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:1023];
  bit   [1023:0] written;

  mips32_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_STARVE(3)) dut (
    .clk1(clk1), .rst(rst), .halted(halted),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Synchronous single-port memory with one-cycle read latency.
  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= written[mem_addr] ? mem[mem_addr] : 32'(mem_addr) + 32'hA;
      end
    end
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle_inputs();
    if_req   = 1'b0;
    if_addr  = '0;
    if_flush = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    halted   = 1'b0;
  endtask

  // Both requesters held: expect DM,DM,DM,IF then DM again (counter started at 0).
  task automatic run_contention(input string tag);
    logic [1:0] exp_g;
    if_req  = 1'b1; if_addr = 10'd3;
    dm_req  = 1'b1; dm_we = 1'b0; dm_addr = 10'd5;
    for (int c = 0; c < 5; c++) begin
      #1;
      exp_g = (c == 3) ? 2'b10 : 2'b01;
      checks++;
      if ({if_gnt, dm_gnt} !== exp_g) begin
        failures++;
        $display("[TB] FAIL %s_grant cycle %0d: got if/dm=%b expected %b", tag, c, {if_gnt, dm_gnt}, exp_g);
      end
      step();
      if (c < 4) begin
        checks++;
        if (c == 3) begin
          if ({if_rvalid, dm_rvalid} !== 2'b10 || if_rdata !== 32'hD) begin
            failures++;
            $display("[TB] FAIL %s_if_return: got rv=%b data=%h expected rv=10 data=0000000d", tag, {if_rvalid, dm_rvalid}, if_rdata);
          end
        end else begin
          if ({if_rvalid, dm_rvalid} !== 2'b01 || dm_rdata !== 32'hF) begin
            failures++;
            $display("[TB] FAIL %s_dm_return cycle %0d: got rv=%b data=%h expected rv=01 data=0000000f", tag, c, {if_rvalid, dm_rvalid}, dm_rdata);
          end
        end
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    if_req = 1'b1; dm_req = 1'b1;
    step();
    checks++;
    if ({if_gnt, dm_gnt, mem_en} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_grants: got %b expected 000", {if_gnt, dm_gnt, mem_en});
    end
    step();
    idle_inputs();
    rst = 1'b0;
    #1;
    checks++;
    if ({if_rvalid, dm_rvalid, mem_en} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got rv/en=%b expected 000", {if_rvalid, dm_rvalid, mem_en});
    end
    step();
  endtask

  task automatic test_if_stream();
    logic [31:0] exp_data [3];
    exp_data[0] = 32'hA; exp_data[1] = 32'hB; exp_data[2] = 32'hC;
    if_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_addr = 10'(i);
      #1;
      checks++;
      if (if_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'(i)) begin
        failures++;
        $display("[TB] FAIL if_stream_grant %0d: got gnt=%b en=%b we=%b addr=%0d expected 1 1 0 %0d", i, if_gnt, mem_en, mem_we, mem_addr, i);
      end
      step();
      checks++;
      if (if_rvalid !== 1'b1 || if_rdata !== exp_data[i]) begin
        failures++;
        $display("[TB] FAIL if_stream_return %0d: got rv=%b data=%h expected rv=1 data=%h", i, if_rvalid, if_rdata, exp_data[i]);
      end
    end
    if_req = 1'b0;
    #1;
    checks++;
    if ({if_gnt, dm_gnt, mem_en, mem_we} !== 4'b0000 || mem_addr !== 10'd0 || mem_wdata !== 32'd0) begin
      failures++;
      $display("[TB] FAIL idle_port: got g/en/we=%b addr=%0d wdata=%h expected 0000 0 0", {if_gnt, dm_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    step();
  endtask

  task automatic test_starvation();
    run_contention("starve");
  endtask

  task automatic test_store_load();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd7; dm_wdata = 32'h1234;
    #1;
    checks++;
    if (dm_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'd7 || mem_wdata !== 32'h1234) begin
      failures++;
      $display("[TB] FAIL store_grant: got gnt=%b we=%b addr=%0d wdata=%h expected 1 1 7 00001234", dm_gnt, mem_we, mem_addr, mem_wdata);
    end
    step();
    checks++;
    if (dm_rvalid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL store_no_resp: got dm_rvalid=%b expected 0", dm_rvalid);
    end
    dm_we = 1'b0; dm_wdata = '0;
    #1;
    checks++;
    if (dm_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd7) begin
      failures++;
      $display("[TB] FAIL load_grant: got gnt=%b we=%b addr=%0d expected 1 0 7", dm_gnt, mem_we, mem_addr);
    end
    step();
    checks++;
    if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h1234) begin
      failures++;
      $display("[TB] FAIL load_return: got rv=%b data=%h expected rv=1 data=00001234", dm_rvalid, dm_rdata);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_addr = 10'd9;
    #1;
    checks++;
    if (if_gnt !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_grant: got if_gnt=%b expected 1", if_gnt);
    end
    step();
    if_req = 1'b0; if_flush = 1'b1;
    #1;
    checks++;
    if (if_rvalid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_return_cycle: got if_rvalid=%b expected 0", if_rvalid);
    end
    if_flush = 1'b0;
    step();
    if_req = 1'b1; if_flush = 1'b1;
    #1;
    checks++;
    if (if_gnt !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_grant_cycle_gnt: got if_gnt=%b expected 1", if_gnt);
    end
    step();
    if_req = 1'b0; if_flush = 1'b0;
    #1;
    checks++;
    if (if_rvalid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_grant_cycle_return: got if_rvalid=%b expected 0", if_rvalid);
    end
    step();
  endtask

  task automatic test_halt();
    // A fetch granted just before halt still returns.
    if_req = 1'b1; if_addr = 10'd2;
    step();
    halted = 1'b1;
    #1;
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hC || if_gnt !== 1'b0) begin
      failures++;
      $display("[TB] FAIL halt_pending_return: got rv=%b data=%h gnt=%b expected rv=1 data=0000000c gnt=0", if_rvalid, if_rdata, if_gnt);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({if_gnt, mem_en, if_rvalid} !== 3'b000) begin
        failures++;
        $display("[TB] FAIL halt_block %0d: got gnt/en/rv=%b expected 000", i, {if_gnt, mem_en, if_rvalid});
      end
    end
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd5;
    #1;
    checks++;
    if ({if_gnt, dm_gnt} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL halt_dm_grant: got if/dm=%b expected 01", {if_gnt, dm_gnt});
    end
    step();
    halted = 1'b0;
    // Halted fetch cycles must not have charged the starvation counter.
    run_contention("post_halt");
  endtask

  task automatic test_reset_mid_op();
    if_req = 1'b1; if_addr = 10'd3;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd5;
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if ({if_gnt, dm_gnt, mem_en} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL rst_mid_grants: got g/en=%b expected 000", {if_gnt, dm_gnt, mem_en});
    end
    step();
    rst = 1'b0;
    checks++;
    if ({if_rvalid, dm_rvalid} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL rst_mid_rvalid: got rv=%b expected 00", {if_rvalid, dm_rvalid});
    end
    run_contention("post_rst");
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_if_stream();
    test_starvation();
    test_store_load();
    test_flush();
    test_halt();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
